// File: rtl/sys_defs.sv
// Shared machine-wide types and defaults used by the CDB and its snoopers.
package sys_defs;

    localparam int XLEN          = 32;
    localparam int ROB_TAG_LEN   = 5;
    localparam int CDB_BUF_DEPTH = 2;
    localparam int NUM_CDB_FU    = 4;

    // One broadcast slot; rob_tag == 0 means "no producer".
    typedef struct packed {
        logic                   valid;
        logic [ROB_TAG_LEN-1:0] rob_tag;
        logic [XLEN-1:0]        value;
    } CDB_DATA;

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-functional-unit result buffer. Push is refused when full (full is
// registered, so a same-edge pop does not make room); pop on empty is ignored.
module cdb_result_fifo
    import sys_defs::*;
#(
    parameter  int DEPTH = CDB_BUF_DEPTH,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush_i,
    input  logic          push_valid_i,
    input  CDB_DATA       push_data_i,
    input  logic          pop_i,
    output CDB_DATA       head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    CDB_DATA       mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok, pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_valid_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer/occupancy update; flush empties the buffer ahead of push/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage write; contents are only observed through head when non-empty.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB transmit end: per-unit result buffers, round-robin pick of one head per
// cycle, registered broadcast.
module cdb_broadcaster
    import sys_defs::*;
#(
    parameter int NUM_FU    = NUM_CDB_FU,
    parameter int BUF_DEPTH = CDB_BUF_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  CDB_DATA [NUM_FU-1:0]  fu_result,
    output logic    [NUM_FU-1:0]  fu_ready,
    input  logic                  flush,
    output CDB_DATA               cdb,
    output logic                  cdb_busy
);

    localparam int FW = $clog2(NUM_FU);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    CDB_DATA [NUM_FU-1:0]         head;
    logic    [NUM_FU-1:0][CW-1:0] count;
    logic    [NUM_FU-1:0]         full, empty, push, pop;

    logic [FW-1:0] rr_ptr_q, rr_ptr_d, winner;
    logic          found;
    int            scan_idx;
    CDB_DATA       cdb_q, cdb_d;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
        // Tag 0 has no consumer, so it is accepted but never stored.
        assign fu_ready[g] = ~full[g];
        assign push[g]     = fu_result[g].valid && fu_ready[g] &&
                             (fu_result[g].rob_tag != '0);

        cdb_result_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
            .clk          (clk),
            .reset        (reset),
            .flush_i      (flush),
            .push_valid_i (push[g]),
            .push_data_i  (fu_result[g]),
            .pop_i        (pop[g]),
            .head_o       (head[g]),
            .count_o      (count[g]),
            .full_o       (full[g]),
            .empty_o      (empty[g])
        );
    end

    // Busy whenever any unit still holds a result.
    always_comb begin
        cdb_busy = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (count[i] != '0) cdb_busy = 1'b1;
        end
    end

    // Round-robin scan from rr_ptr; first non-empty buffer wins and is popped.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NUM_FU) scan_idx = scan_idx - NUM_FU;
            if (!found && !empty[scan_idx]) begin
                found  = 1'b1;
                winner = FW'(scan_idx);
            end
        end
        pop      = '0;
        rr_ptr_d = rr_ptr_q;
        cdb_d    = '0;
        if (found) begin
            pop[winner]   = 1'b1;
            rr_ptr_d      = (winner == FW'(NUM_FU - 1)) ? '0 : winner + FW'(1);
            cdb_d         = head[winner];
            cdb_d.valid   = 1'b1;
        end
    end

    // Broadcast register and fairness pointer; flush squashes the in-flight pick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cdb_q    <= '0;
            rr_ptr_q <= '0;
        end else if (flush) begin
            cdb_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            cdb_q    <= cdb_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign cdb = cdb_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed bench for cdb_broadcaster: inputs change and outputs are sampled on
// the falling edge, the DUT updates on the rising edge.
module tb_cdb_broadcaster;
    import sys_defs::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    CDB_DATA [3:0]    fu_result;
    logic    [3:0]    fu_ready;
    CDB_DATA          cdb;
    logic             cdb_busy;

    int n_tests = 0;
    int n_fail  = 0;

    cdb_broadcaster #(.NUM_FU(4), .BUF_DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .fu_result (fu_result),
        .fu_ready  (fu_ready),
        .flush     (flush),
        .cdb       (cdb),
        .cdb_busy  (cdb_busy)
    );

    always #5 clk = ~clk;

    function automatic CDB_DATA mk(input int tag, input int val);
        CDB_DATA d;
        d.valid   = 1'b1;
        d.rob_tag = ROB_TAG_LEN'(tag);
        d.value   = XLEN'(val);
        return d;
    endfunction

    task automatic clear_inputs();
        fu_result = '0;
        flush     = 1'b0;
    endtask

    task automatic set_fu(input int u, input int tag, input int val);
        fu_result[u] = mk(tag, val);
    endtask

    task automatic flush_pulse();
        clear_inputs();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({cdb, fu_ready, cdb_busy} !== {CDB_DATA'('0), 4'hf, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: cdb=%h ready=%b busy=%b, want cdb=0 ready=1111 busy=0",
                     cdb, fu_ready, cdb_busy);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_tests++;
            if ({cdb.valid, fu_ready, cdb_busy} !== {1'b0, 4'hf, 1'b0}) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: valid=%b ready=%b busy=%b, want 0 1111 0",
                         i, cdb.valid, fu_ready, cdb_busy);
            end
        end
    endtask

    task automatic test_single();
        set_fu(2, 5, 'h1234);
        @(negedge clk);
        clear_inputs();
        n_tests++;
        if ({cdb.valid, cdb_busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL single_no_bypass: valid=%b busy=%b, want valid=0 busy=1",
                     cdb.valid, cdb_busy);
        end
        @(negedge clk);
        n_tests++;
        if (cdb !== mk(5, 'h1234)) begin
            n_fail++;
            $display("FAIL single_broadcast: cdb=%h, want %h", cdb, mk(5, 'h1234));
        end
        @(negedge clk);
        n_tests++;
        if ({cdb.valid, cdb_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_one_shot: valid=%b busy=%b, want 0 0", cdb.valid, cdb_busy);
        end
    endtask

    task automatic test_contention();
        flush_pulse();
        for (int u = 0; u < 4; u++) set_fu(u, u + 1, 'hA0 + u);
        @(negedge clk);
        clear_inputs();
        n_tests++;
        if (cdb.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL contention_latency: valid=%b, want 0", cdb.valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (cdb !== mk(i + 1, 'hA0 + i)) begin
                n_fail++;
                $display("FAIL contention_order%0d: cdb=%h, want %h", i, cdb, mk(i + 1, 'hA0 + i));
            end
        end
        // Pointer is back at unit 0 and everything drained.
        set_fu(0, 7, 'h77);
        @(negedge clk);
        clear_inputs();
        n_tests++;
        if ({cdb.valid, cdb_busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL contention_tag7_wait: valid=%b busy=%b, want 0 1", cdb.valid, cdb_busy);
        end
        @(negedge clk);
        n_tests++;
        if (cdb !== mk(7, 'h77)) begin
            n_fail++;
            $display("FAIL contention_tag7: cdb=%h, want %h", cdb, mk(7, 'h77));
        end
    endtask

    task automatic test_tag0();
        set_fu(3, 0, 'hdead);
        @(negedge clk);
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({cdb.valid, cdb_busy, fu_ready} !== {2'b00, 4'hf}) begin
                n_fail++;
                $display("FAIL tag0_drop%0d: valid=%b busy=%b ready=%b, want 0 0 1111",
                         i, cdb.valid, cdb_busy, fu_ready);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_pressure();
        int       exp_tag [13];
        logic [3:0] exp_rdy [13];
        int       n0, n1;
        exp_tag = '{0, 0, 10, 20, 11, 21, 12, 22, 13, 23, 14, 24, 0};
        exp_rdy = '{4'b1111, 4'b1111, 4'b1101, 4'b1110, 4'b1101, 4'b1110, 4'b1101,
                    4'b1110, 4'b1101, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
        n0 = 0;
        n1 = 0;
        flush_pulse();
        for (int k = 0; k < 13; k++) begin
            if (k > 0) @(negedge clk);
            n_tests++;
            if (fu_ready !== exp_rdy[k]) begin
                n_fail++;
                $display("FAIL bp_ready%0d: ready=%b, want %b", k, fu_ready, exp_rdy[k]);
            end
            n_tests++;
            if (exp_tag[k] == 0) begin
                if (cdb.valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_cdb%0d: cdb=%h, want invalid", k, cdb);
                end
            end else if (cdb !== mk(exp_tag[k], 'h1000 + exp_tag[k])) begin
                n_fail++;
                $display("FAIL bp_cdb%0d: cdb=%h, want %h", k, cdb,
                         mk(exp_tag[k], 'h1000 + exp_tag[k]));
            end
            if (k <= 7) begin
                set_fu(0, 10 + n0, 'h1000 + 10 + n0);
                set_fu(1, 20 + n1, 'h1000 + 20 + n1);
                if (exp_rdy[k][0]) n0++;
                if (exp_rdy[k][1]) n1++;
            end else begin
                clear_inputs();
            end
        end
        n_tests++;
        if (cdb_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drained: busy=%b, want 0", cdb_busy);
        end
    endtask

    task automatic test_flush();
        set_fu(0, 11, 'hB0);
        set_fu(2, 12, 'hB2);
        set_fu(3, 13, 'hB3);
        @(negedge clk);
        clear_inputs();
        n_tests++;
        if ({cdb.valid, cdb_busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_setup: valid=%b busy=%b, want 0 1", cdb.valid, cdb_busy);
        end
        flush = 1'b1;
        set_fu(1, 9, 'hB1);
        @(negedge clk);
        clear_inputs();
        n_tests++;
        if ({cdb.valid, cdb_busy, fu_ready} !== {2'b00, 4'hf}) begin
            n_fail++;
            $display("FAIL flush_clear: valid=%b busy=%b ready=%b, want 0 0 1111",
                     cdb.valid, cdb_busy, fu_ready);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if ({cdb.valid, cdb_busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL flush_quiet%0d: cdb=%h busy=%b, want invalid 0", i, cdb, cdb_busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int u = 0; u < 4; u++) set_fu(u, u + 1, 'hC0 + u);
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        n_tests++;
        if (cdb !== mk(1, 'hC0)) begin
            n_fail++;
            $display("FAIL rstmid_burst: cdb=%h, want %h", cdb, mk(1, 'hC0));
        end
        reset = 1'b1;
        flush = 1'b1;
        #1;
        n_tests++;
        if ({cdb, cdb_busy, fu_ready} !== {CDB_DATA'('0), 1'b0, 4'hf}) begin
            n_fail++;
            $display("FAIL rstmid_async: cdb=%h busy=%b ready=%b, want 0 0 1111",
                     cdb, cdb_busy, fu_ready);
        end
        @(negedge clk);
        n_tests++;
        if ({cdb, cdb_busy} !== {CDB_DATA'('0), 1'b0}) begin
            n_fail++;
            $display("FAIL rstmid_held: cdb=%h busy=%b, want 0 0", cdb, cdb_busy);
        end
        reset = 1'b0;
        flush = 1'b0;
        set_fu(2, 6, 'h66);
        @(negedge clk);
        clear_inputs();
        n_tests++;
        if ({cdb.valid, cdb_busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL rstmid_first_push: valid=%b busy=%b, want 0 1", cdb.valid, cdb_busy);
        end
        @(negedge clk);
        n_tests++;
        if (cdb !== mk(6, 'h66)) begin
            n_fail++;
            $display("FAIL rstmid_after: cdb=%h, want %h", cdb, mk(6, 'h66));
        end
        @(negedge clk);
        n_tests++;
        if ({cdb.valid, cdb_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL rstmid_no_stale: cdb=%h busy=%b, want invalid 0", cdb, cdb_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_tag0();
        test_back_pressure();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
